// File: rtl/mem_arbiter.sv
// Single-port RAM scheduler shared by the fetch stage and the MEM stage.
// Data has priority; a one-shot fairness flag hands the port to fetch after a data access.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DGRANT = 2'd1;
  localparam logic [1:0] ST_IGRANT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_d_q, last_d_d;
  logic             err_q, err_d;

  logic d_pend;
  logic owner_req;
  logic access_done;

  assign d_pend = dREN | dWEN;

  // The owner's request must still be up for any RAM strobe or completion to count.
  always_comb begin
    owner_req = 1'b0;
    if (state_q == ST_DGRANT)      owner_req = d_pend;
    else if (state_q == ST_IGRANT) owner_req = iREN;
  end

  // A reset landing on the completing cycle suppresses the pulse.
  assign access_done = owner_req && (ramstate == RAM_ACCESS) && !RST;

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      ST_DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      ST_IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: ;
    endcase
  end

  always_comb begin
    iwait = ~(access_done && (state_q == ST_IGRANT));
    dwait = ~(access_done && (state_q == ST_DGRANT));
    iload = iwait ? '0 : ramload;
    dload = dwait ? '0 : ramload;
    err   = err_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d_d = last_d_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (d_pend && iREN) state_d = last_d_q ? ST_IGRANT : ST_DGRANT;
        else if (d_pend)    state_d = ST_DGRANT;
        else if (iREN)      state_d = ST_IGRANT;
      end
      default: begin
        // Any exit from a grant returns to IDLE, which forces the idle bubble.
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!owner_req) begin
          err_d = err_q;
        end else if (ramstate == RAM_ERROR) begin
          err_d = 1'b1;
        end else if (ramstate == RAM_ACCESS) begin
          last_d_d = (state_q == ST_DGRANT);
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
        end else begin
          state_d = state_q;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_d_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level ownership model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic              iREN, dREN, dWEN;
  logic [ADDR_W-1:0] iaddr, daddr;
  logic [DATA_W-1:0] dstore, ramload;
  logic [1:0]        ramstate;
  logic              iwait, dwait, ramREN, ramWEN, err;
  logic [DATA_W-1:0] iload, dload, ramstore;
  logic [ADDR_W-1:0] ramaddr;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Model: who holds the port (0 nobody, 1 data, 2 fetch) and for how many cycles.
  int owner = 0;
  int held  = 0;
  bit m_last_d = 1'b0;
  bit m_err = 1'b0;
  bit model_valid = 1'b0;

  function automatic bit owner_wants();
    if (owner == 1) return dREN | dWEN;
    if (owner == 2) return iREN;
    return 1'b0;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      owner = 0; held = 0; m_last_d = 1'b0; m_err = 1'b0; model_valid = 1'b1;
    end else if (owner == 0) begin
      held = 0;
      if ((dREN | dWEN) && iREN) owner = m_last_d ? 2 : 1;
      else if (dREN | dWEN)      owner = 1;
      else if (iREN)             owner = 2;
    end else if (!owner_wants()) begin
      owner = 0;
    end else if (ramstate == 2'd3) begin
      m_err = 1'b1; owner = 0;
    end else if (ramstate == 2'd2) begin
      m_last_d = (owner == 1); owner = 0;
    end else begin
      held = held + 1;
      if (held == TIMEOUT) begin
        m_err = 1'b1; owner = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      bit fin, e_iw, e_dw, e_ren, e_wen;
      logic [31:0] e_addr, e_store;
      fin     = owner_wants() && (ramstate == 2'd2) && !RST;
      e_iw    = !(fin && owner == 2);
      e_dw    = !(fin && owner == 1);
      e_ren   = (owner == 2 && iREN) || (owner == 1 && dREN && !dWEN);
      e_wen   = (owner == 1 && dWEN);
      e_addr  = (owner == 2) ? iaddr : (owner == 1) ? daddr : 32'h0;
      e_store = (owner == 1) ? dstore : 32'h0;
      check("m_iwait", 32'(iwait), 32'(e_iw));
      check("m_dwait", 32'(dwait), 32'(e_dw));
      check("m_iload", iload, e_iw ? 32'h0 : ramload);
      check("m_dload", dload, e_dw ? 32'h0 : ramload);
      check("m_ramREN", 32'(ramREN), 32'(e_ren));
      check("m_ramWEN", 32'(ramWEN), 32'(e_wen));
      check("m_ramaddr", ramaddr, e_addr);
      check("m_ramstore", ramstore, e_store);
      check("m_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b1; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;

    // Reset held with a data request pending.
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("rst_ramREN", 32'(ramREN), 32'd0);
      check("rst_dwait", 32'(dwait), 32'd1);
      check("rst_iwait", 32'(iwait), 32'd1);
      check("rst_err", 32'(err), 32'd0);
    end
    RST = 1'b0; dREN = 1'b0;
    tick();

    // Fetch only, RAM answers two cycles after the strobe.
    iREN = 1'b1; iaddr = 32'h40; #1;
    check("f_idle_ren", 32'(ramREN), 32'd0);
    tick(); ramstate = 2'd1; #1;
    check("f_ren", 32'(ramREN), 32'd1);
    check("f_addr", ramaddr, 32'h40);
    check("f_iwait_busy", 32'(iwait), 32'd1);
    tick();
    tick(); ramstate = 2'd2; ramload = 32'hDEADBEEF; #1;
    check("f_iwait_done", 32'(iwait), 32'd0);
    check("f_iload", iload, 32'hDEADBEEF);
    tick(); iREN = 1'b0; ramstate = 2'd0; #1;
    check("f_after_iwait", 32'(iwait), 32'd1);
    check("f_after_iload", iload, 32'h0);
    check("f_after_ren", 32'(ramREN), 32'd0);
    tick();

    // Simultaneous requests: data first, then fetch even though data stays up.
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h5;
    tick(); ramstate = 2'd1; #1;
    check("s_wen", 32'(ramWEN), 32'd1);
    check("s_ren", 32'(ramREN), 32'd0);
    check("s_addr", ramaddr, 32'h100);
    check("s_store", ramstore, 32'h5);
    tick(); ramstate = 2'd2; #1;
    check("s_dwait_done", 32'(dwait), 32'd0);
    check("s_iwait_held", 32'(iwait), 32'd1);
    tick(); ramstate = 2'd0; #1;
    check("s_bubble_wen", 32'(ramWEN), 32'd0);
    check("s_bubble_dwait", 32'(dwait), 32'd1);
    tick(); ramstate = 2'd2; ramload = 32'h1234; #1;
    check("s_fair_ren", 32'(ramREN), 32'd1);
    check("s_fair_wen", 32'(ramWEN), 32'd0);
    check("s_fair_addr", ramaddr, 32'h40);
    check("s_fair_iwait", 32'(iwait), 32'd0);
    check("s_fair_iload", iload, 32'h1234);
    tick(); iREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
    tick();

    // Withdrawal during a busy data read.
    dREN = 1'b1; daddr = 32'h200;
    tick(); ramstate = 2'd1; #1;
    check("w_ren_up", 32'(ramREN), 32'd1);
    dREN = 1'b0; #1;
    check("w_ren_drop", 32'(ramREN), 32'd0);
    check("w_dwait", 32'(dwait), 32'd1);
    tick(); ramstate = 2'd0; #1;
    check("w_err", 32'(err), 32'd0);
    check("w_idle_ren", 32'(ramREN), 32'd0);
    tick();

    // Timeout: RAM stuck BUSY for TIMEOUT grant cycles.
    dREN = 1'b1; daddr = 32'h300; ramstate = 2'd1;
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      #1;
      check("t_ren", 32'(ramREN), 32'd1);
      check("t_dwait", 32'(dwait), 32'd1);
      check("t_err_low", 32'(err), 32'd0);
      tick();
    end
    dREN = 1'b0; #1;
    check("t_err_set", 32'(err), 32'd1);
    check("t_idle_ren", 32'(ramREN), 32'd0);
    tick(); tick(); #1;
    check("t_err_sticky", 32'(err), 32'd1);
    RST = 1'b1; ramstate = 2'd0;
    tick(); RST = 1'b0; #1;
    check("t_err_cleared", 32'(err), 32'd0);

    // ERROR response on a fetch, then the fetch is re-granted.
    iREN = 1'b1; iaddr = 32'h80;
    tick(); ramstate = 2'd3; #1;
    check("e_ren", 32'(ramREN), 32'd1);
    check("e_iwait", 32'(iwait), 32'd1);
    check("e_err_low", 32'(err), 32'd0);
    tick(); ramstate = 2'd0; #1;
    check("e_err_set", 32'(err), 32'd1);
    check("e_idle_ren", 32'(ramREN), 32'd0);
    check("e_iwait_idle", 32'(iwait), 32'd1);
    tick(); ramstate = 2'd2; ramload = 32'hCAFE; #1;
    check("e_regrant_addr", ramaddr, 32'h80);
    check("e_regrant_iwait", 32'(iwait), 32'd0);
    check("e_regrant_iload", iload, 32'hCAFE);
    tick(); iREN = 1'b0; ramstate = 2'd0;
    tick();

    // Reset arriving on the completing cycle suppresses the pulse.
    dREN = 1'b1; daddr = 32'h400;
    tick(); ramstate = 2'd2; ramload = 32'h77; RST = 1'b1; #1;
    check("r_no_pulse", 32'(dwait), 32'd1);
    check("r_dload", dload, 32'h0);
    tick(); RST = 1'b0; dREN = 1'b0; ramstate = 2'd0; #1;
    check("r_idle_ren", 32'(ramREN), 32'd0);
    check("r_err", 32'(err), 32'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
